// File: rtl/deint_pkg.sv
// Shared types and helpers for the block deinterleaver: bank state encoding,
// default geometry and address-width sizing.
package deint_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 11;
    localparam int DEF_DATA_W = 8;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Drain events take priority: a bank cannot be filled and drained in the
    // same cycle because the two sides only ever touch banks in disjoint states.
    function automatic bank_state_t bank_next(
        input bank_state_t cur,
        input logic        fill_start,
        input logic        fill_done,
        input logic        drain_start,
        input logic        drain_done
    );
        bank_state_t nxt;
        nxt = cur;
        if (drain_done) begin
            nxt = EMPTY;
        end else if (drain_start) begin
            nxt = DRAINING;
        end else if (fill_done) begin
            nxt = FULL;
        end else if (fill_start) begin
            nxt = FILLING;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/deint_wr_addr_gen.sv
// Write-address generator: row counter (inner) and column counter (outer) walk
// the row-major slot of each column-major arrival; the address tracks them by addition only.
module deint_wr_addr_gen
    import deint_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = addr_w(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset_or_restart,
    input  logic              advance,
    input  logic              sync_clear,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int ROW_W = addr_w(ROWS);
    localparam int COL_W = addr_w(COLS);

    logic [ROW_W-1:0]  row_reg, row_next, row_cur;
    logic [COL_W-1:0]  col_reg, col_next, col_cur;
    logic [ADDR_W-1:0] addr_reg, addr_next, addr_cur;

    // sync_clear makes the current symbol behave as k=0; combined with advance
    // the counters land on k=1, exactly as if the block had started here.
    always_comb begin
        row_cur   = sync_clear ? '0 : row_reg;
        col_cur   = sync_clear ? '0 : col_reg;
        addr_cur  = sync_clear ? '0 : addr_reg;
        addr      = addr_cur;
        last      = (row_cur == ROW_W'(ROWS - 1)) && (col_cur == COL_W'(COLS - 1));
        row_next  = row_cur;
        col_next  = col_cur;
        addr_next = addr_cur;
        if (advance) begin
            if (row_cur == ROW_W'(ROWS - 1)) begin
                row_next = '0;
                if (col_cur == COL_W'(COLS - 1)) begin
                    col_next  = '0;
                    addr_next = '0;
                end else begin
                    col_next  = col_cur + 1'b1;
                    addr_next = ADDR_W'(col_next);
                end
            end else begin
                row_next  = row_cur + 1'b1;
                addr_next = addr_cur + ADDR_W'(COLS);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_or_restart) begin
        if (reset_or_restart) begin
            row_reg  <= '0;
            col_reg  <= '0;
            addr_reg <= '0;
        end else begin
            row_reg  <= row_next;
            col_reg  <= col_next;
            addr_reg <= addr_next;
        end
    end

endmodule

// File: rtl/block_deinterleaver.sv
// Ping-pong block deinterleaver: column-major input written to row-major slots,
// streamed out linearly. Optional in_sof resync when DEINT_RESYNC_EN is defined.
module block_deinterleaver
    import deint_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_or_restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef DEINT_RESYNC_EN
    input  logic              in_sof,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int N      = ROWS * COLS;
    localparam int ADDR_W = addr_w(N);
    // Bank select is the address MSB, so each bank spans a power-of-two window.
    localparam int MEM_DEPTH = 2 * (2 ** ADDR_W);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    bank_state_t       state_reg  [2];
    bank_state_t       state_next [2];
    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;

    logic              wr_fire;
    logic              sync_clear;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_last;
    logic              rd_active;
    logic              rd_load;
    logic              rd_last;
    logic [1:0]        fill_start;
    logic [1:0]        fill_done;
    logic [1:0]        drain_start;
    logic [1:0]        drain_done;

    assign in_ready = (state_reg[wr_bank_reg] == EMPTY) || (state_reg[wr_bank_reg] == FILLING);
    assign wr_fire  = in_valid && in_ready;

`ifdef DEINT_RESYNC_EN
    // At k=0 the clear is a no-op, so no separate start-of-block qualifier is needed.
    assign sync_clear = wr_fire && in_sof;
`else
    assign sync_clear = 1'b0;
`endif

    deint_wr_addr_gen #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_wr_addr_gen (
        .clk              (clk),
        .reset_or_restart (reset_or_restart),
        .advance          (wr_fire),
        .sync_clear       (sync_clear),
        .addr             (wr_addr),
        .last             (wr_last)
    );

    assign rd_active = (state_reg[rd_bank_reg] == FULL) || (state_reg[rd_bank_reg] == DRAINING);
    assign rd_load   = rd_active && (!out_valid || out_ready);
    assign rd_last   = (rd_ptr_reg == ADDR_W'(N - 1));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign fill_start[gi]  = wr_fire && (wr_bank_reg == 1'(gi)) && (state_reg[gi] == EMPTY);
            assign fill_done[gi]   = wr_fire && (wr_bank_reg == 1'(gi)) && wr_last;
            assign drain_start[gi] = rd_load && (rd_bank_reg == 1'(gi)) && (state_reg[gi] == FULL);
            assign drain_done[gi]  = rd_load && (rd_bank_reg == 1'(gi)) && rd_last;
            assign state_next[gi]  = bank_next(state_reg[gi], fill_start[gi], fill_done[gi],
                                               drain_start[gi], drain_done[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset_or_restart) begin
        if (reset_or_restart) begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b] <= EMPTY;
            end
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            rd_ptr_reg  <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_reg[b] <= state_next[b];
            end
            wr_bank_reg <= wr_bank_reg ^ (|fill_done);
            rd_bank_reg <= rd_bank_reg ^ (|drain_done);
            if (rd_load) begin
                rd_ptr_reg <= rd_last ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_reg, wr_addr}] <= in_data;
        end
    end

    // Output register doubles as the stall buffer: it only reloads once the
    // current symbol has been taken.
    always_ff @(posedge clk or posedge reset_or_restart) begin
        if (reset_or_restart) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (rd_load) begin
            out_valid <= 1'b1;
            out_data  <= mem[{rd_bank_reg, rd_ptr_reg}];
            out_last  <= rd_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
